bram_stream_sched: RTL and testbench

Controller that streams a block of 256-bit stimulus words from the input BRAM into the multiplier datapath (`top_allone_bram_ctrl`), honours its valid/ready handshake, and writes every result word into a result BRAM. It sits between the host-loaded BRAMs and the datapath. It latches the operating mode per run and reports busy, done and error status to the host.

---
 rtl/sched_pkg.sv | 17 +
 rtl/sched_fifo2.sv | 57 +++++
 rtl/bram_stream_sched.sv | 185 ++++++++++++++++++
 tb/tb_bram_stream_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared state encoding and default widths for the BRAM stream scheduler
package sched_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 256;
  localparam int DW          = 16;
  localparam int OUT_W_DEF   = 4 * DW;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sched_fifo2.sv
// rtl/sched_fifo2.sv - 2-entry first-word-fall-through FIFO between the input BRAM and the datapath
module sched_fifo2
  import sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [1:0]        o_count,
  output logic              o_empty,
  output logic              o_full
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // An empty FIFO passes the incoming word straight through so BRAM data reaches the datapath the cycle it arrives
  assign o_head    = (r_count != 2'd0) ? r_mem[r_rd_ptr] : (i_push ? i_din : '0);
  assign o_empty   = (r_count == 2'd0) && !i_push;
  assign o_full    = (r_count == 2'd2);
  assign o_count   = r_count;
  assign w_do_push = i_push && !((r_count == 2'd0) && i_pop);
  assign w_do_pop  = i_pop && (r_count != 2'd0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clr) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

endmodule

// File: rtl/bram_stream_sched.sv
// rtl/bram_stream_sched.sv - streams input-BRAM words into the datapath and writes results to the result BRAM
module bram_stream_sched
  import sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_res_base,
  input  logic [ADDR_W:0]   i_length,
  input  logic [1:0]        i_mode_cfg,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_in_en,
  output logic [ADDR_W-1:0] o_in_addr,
  input  logic [DATA_W-1:0] i_in_dout,
  output logic [DATA_W-1:0] o_dp_in,
  output logic              o_dp_in_vld,
  input  logic              i_dp_in_ready,
  output logic [1:0]        o_dp_mode,
  input  logic [OUT_W-1:0]  i_dp_out,
  input  logic              i_dp_out_vld,
  output logic              o_res_we,
  output logic [ADDR_W-1:0] o_res_addr,
  output logic [OUT_W-1:0]  o_res_din
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT) + 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W-1:0]  r_res_base;
  logic [CNT_W-1:0]   r_length;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [CNT_W-1:0]   r_acc_cnt;
  logic [CNT_W-1:0]   r_out_cnt;
  logic               r_rd_pend;
  logic               r_err;
  logic [TO_W-1:0]    r_idle_cnt;
  logic               r_res_we;
  logic [ADDR_W-1:0]  r_res_addr;
  logic [OUT_W-1:0]   r_res_din;

  logic               w_start_acc;
  logic               w_in_en;
  logic               w_busy;
  logic               w_hs;
  logic               w_out_acc;
  logic               w_out_drop;
  logic               w_timeout;
  logic [DATA_W-1:0]  w_fifo_head;
  logic [1:0]         w_fifo_count;
  logic               w_fifo_empty;
  logic               w_fifo_full;

  sched_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start_acc),
    .i_push  (r_rd_pend),
    .i_din   (i_in_dout),
    .i_pop   (w_hs),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign w_start_acc = i_start && (r_state == IDLE);
  assign w_hs        = !w_fifo_empty && i_dp_in_ready;
  assign w_out_acc   = i_dp_out_vld && w_busy && (r_out_cnt < r_length);
  assign w_out_drop  = i_dp_out_vld && !w_out_acc;
  assign w_timeout   = (r_state == DRAIN) && !i_dp_out_vld && (r_idle_cnt == TO_W'(TIMEOUT - 1));

  assign o_busy      = w_busy;
  assign o_err       = r_err;
  assign o_in_en     = w_in_en;
  assign o_in_addr   = r_base + r_rd_cnt[ADDR_W-1:0];
  assign o_dp_in     = w_fifo_head;
  assign o_dp_in_vld = !w_fifo_empty;
  assign o_dp_mode   = r_mode;
  assign o_res_we    = r_res_we;
  assign o_res_addr  = r_res_addr;
  assign o_res_din   = r_res_din;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    o_done      = 1'b0;
    w_in_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_acc) begin
          w_state_nxt = (i_length == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        w_busy = 1'b1;
        // Stored words plus the read landing this cycle never exceed the FIFO depth
        w_in_en = (r_rd_cnt < r_length) && !w_fifo_full &&
                  (({1'b0, w_fifo_count} + {2'b00, r_rd_pend}) < 3'd2);
        if ((r_rd_cnt == r_length) && (r_acc_cnt == r_length) && w_fifo_empty) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_busy = 1'b1;
        if ((r_out_cnt == r_length) || w_timeout) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_base     <= '0;
      r_res_base <= '0;
      r_length   <= '0;
      r_mode     <= 2'd0;
      r_rd_cnt   <= '0;
      r_acc_cnt  <= '0;
      r_out_cnt  <= '0;
      r_rd_pend  <= 1'b0;
      r_err      <= 1'b0;
      r_idle_cnt <= '0;
      r_res_we   <= 1'b0;
      r_res_addr <= '0;
      r_res_din  <= '0;
    end else begin
      r_rd_pend <= w_in_en;
      r_res_we  <= w_out_acc;
      if (w_out_acc) begin
        r_res_addr <= r_res_base + r_out_cnt[ADDR_W-1:0];
        r_res_din  <= i_dp_out;
      end
      if (w_start_acc) begin
        r_base     <= i_base_addr;
        r_res_base <= i_res_base;
        r_length   <= i_length;
        r_mode     <= i_mode_cfg;
        r_rd_cnt   <= '0;
        r_acc_cnt  <= '0;
        r_out_cnt  <= '0;
        r_err      <= 1'b0;
      end else begin
        if (w_in_en)   r_rd_cnt  <= r_rd_cnt + 1'b1;
        if (w_hs)      r_acc_cnt <= r_acc_cnt + 1'b1;
        if (w_out_acc) r_out_cnt <= r_out_cnt + 1'b1;
      end
      // A stray result or a stalled drain outranks the clear from a coincident start
      if (w_out_drop || w_timeout) begin
        r_err <= 1'b1;
      end
      if ((r_state == DRAIN) && !i_dp_out_vld) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_sched.sv
// tb/tb_bram_stream_sched.sv - randomized directed bench for bram_stream_sched against a queue-based reference
module tb_bram_stream_sched;

  localparam int AW = 11;
  localparam int DWD = 256;
  localparam int OW = 64;
  localparam int DEPTH = 2048;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [AW-1:0]  res_base = '0;
  logic [AW:0]    length = '0;
  logic [1:0]     mode_cfg = '0;
  logic           busy, done, err, in_en, dp_in_vld, res_we;
  logic [AW-1:0]  in_addr, res_addr;
  logic [DWD-1:0] in_dout, dp_in;
  logic           dp_in_ready = 1'b0;
  logic [1:0]     dp_mode;
  logic [OW-1:0]  dp_out, res_din;
  logic           dp_out_vld;
  logic           respond = 1'b1;
  logic           stray = 1'b0;

  logic [DWD-1:0] in_mem  [DEPTH];
  logic [OW-1:0]  res_mem [DEPTH];
  logic [3:0]     pv;
  logic [OW-1:0]  pd [4];
  logic [DWD-1:0] acc_q [$];

  int checks = 0, errors = 0, cyc = 0;
  int done_cnt, done_cyc, we_cnt, last_we_cyc, issued, accepted, last_hs_cyc;
  int rd_addr_q [$];
  logic           prev_stall;
  logic [DWD-1:0] prev_din;

  always #5 clk = ~clk;

  bram_stream_sched dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_res_base(res_base), .i_length(length), .i_mode_cfg(mode_cfg),
    .o_busy(busy), .o_done(done), .o_err(err), .o_in_en(in_en),
    .o_in_addr(in_addr), .i_in_dout(in_dout), .o_dp_in(dp_in),
    .o_dp_in_vld(dp_in_vld), .i_dp_in_ready(dp_in_ready), .o_dp_mode(dp_mode),
    .i_dp_out(dp_out), .i_dp_out_vld(dp_out_vld), .o_res_we(res_we),
    .o_res_addr(res_addr), .o_res_din(res_din)
  );

  function automatic logic [OW-1:0] dp_fn(input logic [DWD-1:0] w);
    return w[63:0] ^ w[127:64] ^ w[255:192];
  endfunction

  // Input BRAM with one cycle read latency, and a datapath answering four cycles after each accepted word
  always @(posedge clk) if (in_en) in_dout <= in_mem[in_addr];
  always @(posedge clk) if (res_we) res_mem[res_addr] <= res_din;
  always @(posedge clk) if (rst && dp_in_vld && dp_in_ready) acc_q.push_back(dp_in);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      for (int i = 0; i < 4; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[2:0], dp_in_vld && dp_in_ready && respond};
      pd[0] <= dp_fn(dp_in);
      for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
    end
  end
  assign dp_out_vld = pv[3] | stray;
  assign dp_out     = pd[3];

  task automatic chk(input string tag, input logic [DWD-1:0] obs, input logic [DWD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    prev_stall = dp_in_vld && !dp_in_ready;
    prev_din   = dp_in;
    if (dp_in_vld && dp_in_ready) begin
      accepted++;
      last_hs_cyc = cyc;
    end
    if (in_en) begin
      issued++;
      rd_addr_q.push_back(int'(in_addr));
    end
    chk("outstanding_le2", DWD'(issued - accepted <= 2), 1);
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (res_we) begin
      we_cnt++;
      last_we_cyc = cyc;
    end
    if (prev_stall && rst) begin
      chk("stall_vld_held", dp_in_vld, 1);
      chk("stall_data_held", dp_in, prev_din);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_in_en"}, in_en, 0);
    chk({tag, "_dp_in_vld"}, dp_in_vld, 0);
    chk({tag, "_res_we"}, res_we, 0);
    chk({tag, "_in_addr"}, in_addr, 0);
    chk({tag, "_res_addr"}, res_addr, 0);
    chk({tag, "_dp_in"}, dp_in, 0);
    chk({tag, "_res_din"}, res_din, 0);
    chk({tag, "_dp_mode"}, dp_mode, 0);
  endtask

  task automatic run(input int base, input int rbase, input int len, input logic [1:0] mode,
                     input bit rnd, input bit resp, input bit exp_err);
    int acc0;
    int n;
    base_addr = AW'(base);
    res_base  = AW'(rbase);
    length    = (AW+1)'(len);
    mode_cfg  = mode;
    respond   = resp;
    rd_addr_q.delete();
    issued = 0; accepted = 0; done_cnt = 0; we_cnt = 0;
    acc0 = acc_q.size();
    dp_in_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy", busy, DWD'(len != 0));
    chk("t1_in_en", in_en, DWD'(len != 0));
    chk("t1_done", done, DWD'(len == 0));
    chk("t1_err_cleared", err, 0);
    chk("t1_dp_mode", dp_mode, mode);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      dp_in_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
      if (n == 1 && !rnd && len > 0) chk("t2_first_vld", dp_in_vld, 1);
      if (n == 1 && !rnd && len > 0) chk("t2_first_word", dp_in, in_mem[base % DEPTH]);
    end
    chk("done_seen", done_cnt, 1);
    chk("busy_low_at_done", busy, 0);
    chk("err_at_done", err, DWD'(exp_err));
    for (int i = 0; i < 3; i++) step();
    chk("single_done_pulse", done_cnt, 1);
    chk("rd_count", rd_addr_q.size(), len);
    for (int i = 0; i < len && i < rd_addr_q.size(); i++)
      chk("in_addr_seq", rd_addr_q[i], (base + i) % DEPTH);
    chk("acc_count", acc_q.size() - acc0, len);
    for (int i = 0; i < len && acc0 + i < acc_q.size(); i++)
      chk("acc_word", acc_q[acc0 + i], in_mem[(base + i) % DEPTH]);
    if (resp) begin
      chk("res_we_count", we_cnt, len);
      for (int i = 0; i < len; i++)
        chk("res_word", res_mem[(rbase + i) % DEPTH], dp_fn(in_mem[(base + i) % DEPTH]));
      if (len > 0) chk("done_after_last_write", done_cyc, last_we_cyc + 1);
    end else begin
      chk("res_we_none", we_cnt, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++)
      in_mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    #3;
    chk_reset("por");
    @(posedge clk); #1; rst = 1'b1;
    step();

    // stray result while idle is dropped and flags an error
    stray = 1'b1;
    step();
    stray = 1'b0;
    chk("stray_err", err, 1);
    chk("stray_no_write", res_we, 0);
    step();

    run(0, 100, 16, 2'd2, 1'b0, 1'b1, 1'b0);
    run(2046, 2046, 4, 2'd1, 1'b0, 1'b1, 1'b0);
    run(5, 5, 0, 2'd3, 1'b0, 1'b1, 1'b0);
    run(int'($urandom_range(0, DEPTH - 1)), 500, 64, 2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0);

    run(300, 900, 8, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("timeout_gap", DWD'((done_cyc - last_hs_cyc) >= 1025 && (done_cyc - last_hs_cyc) <= 1027), 1);

    // asynchronous reset in the middle of a stream
    base_addr = AW'(10); res_base = AW'(1500); length = 12'd64; mode_cfg = 2'd3;
    dp_in_ready = 1'b1; respond = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_run_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(posedge clk); #1; rst = 1'b1; cyc++;
    chk("post_rst_no_done", done, 0);
    run(20, 1200, 16, 2'd1, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
